// File: rtl/sys_debug_fifo_if.sv
// Wishbone slave bus bundle for the debug capture FIFO.
// Members: cyc/stb/we/sel/adr/dat_i from host, dat_o/ack/err to host.
interface sys_debug_fifo_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        output wb_sel_i,
        output wb_adr_i,
        output wb_dat_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o
    );

    modport slave (
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_sel_i,
        input  wb_adr_i,
        input  wb_dat_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o
    );
endinterface

// File: rtl/sys_debug_fifo.sv
// Debug capture FIFO drained by the host over a Wishbone slave port.
// Ports: wb_clk_i, wb_rst_n_i, wb (slave bus), fifo_wr_in/fifo_wr_en push
// side, fifo_nonempty_o registered "count != 0" flag.
// Registers (adr[3:2]): 0 DATA pop, 1 STATUS, 2 CTRL, 3 DROP counter.
module sys_debug_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    sys_debug_fifo_if.slave   wb,
    input  logic [DATA_W-1:0] fifo_wr_in,
    input  logic              fifo_wr_en,
    output logic              fifo_nonempty_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_DROP = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic              overflow;
    logic              underflow;
    logic [15:0]       drop_cnt;
    logic              ack_q;
    logic [31:0]       dat_q;

    logic              req;
    logic              rd;
    logic              wr;
    logic [1:0]        reg_sel;
    logic              pop_req;
    logic              pop_ok;
    logic              push_ok;
    logic              drop;
    logic              flush;
    logic              clear;
    logic              empty;
    logic              full;
    logic [31:0]       status;
    logic [31:0]       rd_data;

    // Byte selects and undecoded address bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4],
                           wb.wb_adr_i[1:0]};

    // Request decode; a request is never taken in the ack cycle, so
    // acks can never appear back to back.
    always_comb begin
        req     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        rd      = req & ~wb.wb_we_i;
        wr      = req & wb.wb_we_i;
        reg_sel = wb.wb_adr_i[3:2];
        pop_req = rd & (reg_sel == REG_DATA);
        flush   = wr & (reg_sel == REG_CTRL) & wb.wb_dat_i[0];
        clear   = wr & (reg_sel == REG_CTRL) & wb.wb_dat_i[1];
        empty   = (count == '0);
        full    = (count == CNT_FULL);
        pop_ok  = pop_req & ~empty;
        // A pop in the same cycle frees the slot a full push needs.
        // Flush discards the word without counting it as a drop.
        push_ok = fifo_wr_en & ~flush & (~full | pop_ok);
        drop    = fifo_wr_en & ~flush & ~push_ok;
    end

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    // STATUS reflects the state before this cycle's push or pop.
    always_comb begin
        status           = '0;
        status[ADDR_W:0] = count;
        status[16]       = empty;
        status[17]       = full;
        status[18]       = overflow;
        status[19]       = underflow;
    end

    always_comb begin
        rd_data = '0;
        if (rd) begin
            unique case (reg_sel)
                REG_DATA: rd_data = pop_ok ? mem[rd_ptr] : '0;
                REG_STAT: rd_data = status;
                REG_CTRL: rd_data = '0;
                REG_DROP: rd_data = {16'h0000, drop_cnt};
                default:  rd_data = '0;
            endcase
        end
    end

    // Storage is left unreset; only the pointers define valid words.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= fifo_wr_in;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
            drop_cnt        <= '0;
            ack_q           <= 1'b0;
            dat_q           <= '0;
            fifo_nonempty_o <= 1'b0;
        end else begin
            ack_q <= req;
            if (req) begin
                dat_q <= rd_data;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            count           <= count_nxt;
            fifo_nonempty_o <= (count_nxt != '0);

            // Clear beats any flag event raised in the same cycle.
            if (clear) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
                drop_cnt  <= '0;
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                if (pop_req && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_err_o = 1'b0;

endmodule

// File: tb/tb_sys_debug_fifo.sv
// Self-checking bench for sys_debug_fifo.
// Directed scenarios plus randomized traffic against a queue model.
module tb_sys_debug_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wr_in;
    logic        wr_en;
    logic        nonempty;

    int tests = 0;
    int fails = 0;

    logic        a;
    logic        a2;
    logic [31:0] d;
    logic [31:0] e;

    logic [31:0] q[$];
    bit          m_ovf;
    bit          m_udf;
    int          m_drop;

    always #5 clk = ~clk;

    sys_debug_fifo_if bus();

    sys_debug_fifo #(
        .ADDR_W(4),
        .DATA_W(32)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_n_i     (rst_n),
        .wb             (bus.slave),
        .fifo_wr_in     (wr_in),
        .fifo_wr_en     (wr_en),
        .fifo_nonempty_o(nonempty)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = '0;
        s[4:0]  = 5'(q.size());
        s[16]   = (q.size() == 0);
        s[17]   = (q.size() == 16);
        s[18]   = m_ovf;
        s[19]   = m_udf;
        return s;
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ovf  = 0;
        m_udf  = 0;
        m_drop = 0;
    endfunction

    // Reference: read effects first, then push, then clear.
    function automatic logic [31:0] m_cycle(input bit push,
                                            input logic [31:0] pdata,
                                            input bit wbr, input bit we,
                                            input logic [1:0] adr,
                                            input logic [31:0] wdat);
        logic [31:0] r;
        bit fl;
        bit cl;
        r  = '0;
        fl = wbr && we && adr == 2 && wdat[0];
        cl = wbr && we && adr == 2 && wdat[1];
        if (wbr && !we) begin
            case (adr)
                2'd0: begin
                    if (q.size() > 0) r = q.pop_front();
                    else m_udf = 1;
                end
                2'd1: r = m_status();
                2'd3: r = 32'(m_drop);
                default: r = '0;
            endcase
        end
        if (fl) begin
            q.delete();
        end else if (push) begin
            if (q.size() < 16) begin
                q.push_back(pdata);
            end else begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
        end
        if (cl) begin
            m_ovf  = 0;
            m_udf  = 0;
            m_drop = 0;
        end
        return r;
    endfunction

    task automatic step(input bit push, input logic [31:0] pdata,
                        input bit wbr, input bit we,
                        input logic [1:0] adr, input logic [31:0] wdat,
                        output logic o_ack, output logic [31:0] o_dat,
                        output logic [31:0] e_dat, output logic o_ack2);
        @(negedge clk);
        wr_en        = push;
        wr_in        = pdata;
        bus.wb_cyc_i = wbr;
        bus.wb_stb_i = wbr;
        bus.wb_we_i  = we;
        bus.wb_sel_i = 4'hF;
        bus.wb_adr_i = {28'h0, adr, 2'b00};
        bus.wb_dat_i = wdat;
        @(posedge clk);
        e_dat = m_cycle(push, pdata, wbr, we, adr, wdat);
        #1;
        o_ack  = bus.wb_ack_o;
        o_dat  = bus.wb_dat_o;
        o_ack2 = 1'b0;
        if (wbr) begin
            @(negedge clk);
            wr_en        = 1'b0;
            bus.wb_cyc_i = 1'b0;
            bus.wb_stb_i = 1'b0;
            bus.wb_we_i  = 1'b0;
            @(posedge clk);
            #1;
            o_ack2 = bus.wb_ack_o;
        end
    endtask

    task automatic test_reset();
        wr_en        = 0;
        wr_in        = 0;
        bus.wb_cyc_i = 0;
        bus.wb_stb_i = 0;
        bus.wb_we_i  = 0;
        bus.wb_sel_i = 0;
        bus.wb_adr_i = 0;
        bus.wb_dat_i = 0;
        rst_n        = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.wb_ack_o, bus.wb_dat_o, nonempty, bus.wb_err_o} !== 35'h0) begin
            fails++;
            $display("FAIL reset_outputs: got ack=%b dat=%h ne=%b err=%b, want 0",
                     bus.wb_ack_o, bus.wb_dat_o, nonempty, bus.wb_err_o);
        end
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (a !== 1'b1 || d !== 32'h0001_0000 || a2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: got ack=%b dat=%h ack2=%b, want 1 00010000 0",
                     a, d, a2);
        end
        tests++;
        if (nonempty !== 1'b0) begin
            fails++;
            $display("FAIL reset_nonempty: got %b, want 0", nonempty);
        end
    endtask

    task automatic test_basic();
        logic [31:0] vals [3];
        vals[0] = 32'h1111_1111;
        vals[1] = 32'h2222_2222;
        vals[2] = 32'h3333_3333;
        step(1, vals[0], 0, 0, 0, 0, a, d, e, a2);
        tests++;
        if (nonempty !== 1'b1) begin
            fails++;
            $display("FAIL basic_nonempty: got %b, want 1", nonempty);
        end
        step(1, vals[1], 0, 0, 0, 0, a, d, e, a2);
        step(1, vals[2], 0, 0, 0, 0, a, d, e, a2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 2'd0, 0, a, d, e, a2);
            tests++;
            if (a !== 1'b1 || a2 !== 1'b0 || d !== vals[i]) begin
                fails++;
                $display("FAIL basic_pop%0d: got ack=%b ack2=%b dat=%h, want 1 0 %h",
                         i, a, a2, d, vals[i]);
            end
        end
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0001_0000 || nonempty !== 1'b0) begin
            fails++;
            $display("FAIL basic_status: got %h ne=%b, want 00010000 ne=0",
                     d, nonempty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            step(1, 32'(i), 0, 0, 0, 0, a, d, e, a2);
        end
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0006_0010) begin
            fails++;
            $display("FAIL ovf_status: got %h, want 00060010", d);
        end
        step(0, 0, 1, 0, 2'd3, 0, a, d, e, a2);
        tests++;
        if (d !== 32'd4) begin
            fails++;
            $display("FAIL ovf_drop: got %h, want 4", d);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 2'd0, 0, a, d, e, a2);
            tests++;
            if (d !== 32'(i) || a !== 1'b1) begin
                fails++;
                $display("FAIL ovf_drain%0d: got %h ack=%b, want %h ack=1",
                         i, d, a, 32'(i));
            end
        end
        step(0, 0, 1, 1, 2'd2, 32'h2, a, d, e, a2);
        tests++;
        if (a !== 1'b1 || a2 !== 1'b0) begin
            fails++;
            $display("FAIL ovf_ctrl_ack: got ack=%b ack2=%b, want 1 0", a, a2);
        end
        step(0, 0, 1, 0, 2'd3, 0, a, d, e, a2);
        tests++;
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL ovf_drop_clr: got %h, want 0", d);
        end
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0001_0000) begin
            fails++;
            $display("FAIL ovf_status_clr: got %h, want 00010000", d);
        end
    endtask

    task automatic test_underflow();
        step(0, 0, 1, 0, 2'd0, 0, a, d, e, a2);
        tests++;
        if (a !== 1'b1 || d !== 32'h0) begin
            fails++;
            $display("FAIL udf_data: got ack=%b dat=%h, want 1 0", a, d);
        end
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0009_0000) begin
            fails++;
            $display("FAIL udf_status: got %h, want 00090000", d);
        end
        step(0, 0, 1, 1, 2'd2, 32'h2, a, d, e, a2);
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0001_0000) begin
            fails++;
            $display("FAIL udf_clear: got %h, want 00010000", d);
        end
    endtask

    task automatic test_full_pushpop();
        logic [31:0] want;
        for (int i = 0; i < 16; i++) begin
            step(1, 32'h100 + 32'(i), 0, 0, 0, 0, a, d, e, a2);
        end
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0002_0010) begin
            fails++;
            $display("FAIL fpp_full: got %h, want 00020010", d);
        end
        step(1, 32'hABCD_0123, 1, 0, 2'd0, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h100) begin
            fails++;
            $display("FAIL fpp_pop: got %h, want 00000100", d);
        end
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0002_0010) begin
            fails++;
            $display("FAIL fpp_status: got %h, want 00020010", d);
        end
        for (int i = 0; i < 16; i++) begin
            want = (i < 15) ? 32'h101 + 32'(i) : 32'hABCD_0123;
            step(0, 0, 1, 0, 2'd0, 0, a, d, e, a2);
            tests++;
            if (d !== want) begin
                fails++;
                $display("FAIL fpp_drain%0d: got %h, want %h", i, d, want);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h500 + 32'(i), 0, 0, 0, 0, a, d, e, a2);
        end
        step(1, 32'hDEAD_BEEF, 1, 1, 2'd2, 32'h1, a, d, e, a2);
        tests++;
        if (nonempty !== 1'b0 || a !== 1'b1) begin
            fails++;
            $display("FAIL flush_ne: got ne=%b ack=%b, want 0 1", nonempty, a);
        end
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0001_0000) begin
            fails++;
            $display("FAIL flush_status: got %h, want 00010000", d);
        end
        step(0, 0, 1, 0, 2'd3, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL flush_drop: got %h, want 0", d);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wr_en        = 1;
        wr_in        = 32'h7777_7777;
        bus.wb_cyc_i = 1;
        bus.wb_stb_i = 1;
        bus.wb_we_i  = 0;
        bus.wb_adr_i = 32'h4;
        @(posedge clk);
        #2;
        tests++;
        if (bus.wb_ack_o !== 1'b1 || nonempty !== 1'b1 ||
            bus.wb_dat_o !== 32'h0001_0000) begin
            fails++;
            $display("FAIL rmid_pre: got ack=%b ne=%b dat=%h, want 1 1 00010000",
                     bus.wb_ack_o, nonempty, bus.wb_dat_o);
        end
        rst_n = 0;
        #1;
        tests++;
        if (bus.wb_ack_o !== 1'b0 || nonempty !== 1'b0 ||
            bus.wb_dat_o !== 32'h0) begin
            fails++;
            $display("FAIL rmid_async: got ack=%b ne=%b dat=%h, want 0 0 0",
                     bus.wb_ack_o, nonempty, bus.wb_dat_o);
        end
        m_reset();
        @(negedge clk);
        wr_en        = 0;
        bus.wb_cyc_i = 0;
        bus.wb_stb_i = 0;
        rst_n        = 1;
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== 32'h0001_0000) begin
            fails++;
            $display("FAIL rmid_status: got %h, want 00010000", d);
        end
    endtask

    task automatic test_random();
        bit push;
        bit wbr;
        bit we;
        logic [1:0] adr;
        logic [31:0] wdat;
        for (int i = 0; i < 400; i++) begin
            push = ($urandom_range(0, 2) != 0);
            wbr  = ($urandom_range(0, 2) == 0);
            we   = ($urandom_range(0, 9) == 0);
            adr  = 2'($urandom_range(0, 3));
            wdat = we ? 32'($urandom_range(0, 3)) : 32'h0;
            if (we && wdat[0] && $urandom_range(0, 1) == 0) wdat[0] = 1'b0;
            step(push, $urandom, wbr, we, adr, wdat, a, d, e, a2);
            if (wbr) begin
                tests++;
                if (a !== 1'b1 || a2 !== 1'b0 || d !== e) begin
                    fails++;
                    $display("FAIL rand%0d adr=%0d we=%b: got ack=%b ack2=%b dat=%h, want 1 0 %h",
                             i, adr, we, a, a2, d, e);
                end
            end
            tests++;
            if (nonempty !== (q.size() != 0)) begin
                fails++;
                $display("FAIL rand%0d_ne: got %b, want %b",
                         i, nonempty, q.size() != 0);
            end
        end
        step(0, 0, 1, 0, 2'd1, 0, a, d, e, a2);
        tests++;
        if (d !== e) begin
            fails++;
            $display("FAIL rand_final_status: got %h, want %h", d, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_full_pushpop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
